data_ram_responder: RTL

- Responder (slave) end of the CPU data-memory bus. Accepts the core's en/write_sel/addr/data_in requests and returns read data on data_out.
- Word-organised synchronous RAM with byte-lane writes.
- Optional programmable wait states, signalled back to the core via a stall output that drives the core's stall_all input.
- Used as the synthesizable replacement for the behavioural data RAM in simulation and on-board builds.

---
 rtl/data_ram_responder.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/data_ram_responder.sv
// Data-memory responder: word-organised RAM with byte-lane writes and optional wait states.
// Optional DATA_RAM_STATS_EN adds rd_count/wr_count completed-access counters.
module data_ram_responder #(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [3:0]  write_sel,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        stall
`ifdef DATA_RAM_STATS_EN
    ,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count
`endif
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    logic [31:0]           mem [DEPTH];
    logic [ADDR_WIDTH-1:0] idx;

    // The access actually performed this edge, from either the live bus or the latched request.
    logic                  do_access;
    logic [3:0]            acc_sel;
    logic [ADDR_WIDTH-1:0] acc_idx;
    logic [31:0]           acc_data;

    // Byte offset and high address bits are ignored; addresses wrap modulo depth.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr[31:ADDR_WIDTH+2], addr[1:0]};
    assign idx = addr[ADDR_WIDTH+1:2];

    generate
        if (WAIT_CYCLES == 0) begin : g_nowait
            assign stall     = 1'b0;
            assign do_access = en;
            assign acc_sel   = write_sel;
            assign acc_idx   = idx;
            assign acc_data  = data_in;
        end else begin : g_wait
            state_t                state;
            state_t                state_next;
            logic [3:0]            cnt;
            logic [3:0]            lat_sel;
            logic [ADDR_WIDTH-1:0] lat_idx;
            logic [31:0]           lat_data;

            always_ff @(posedge clk) begin
                if (rst) begin
                    state    <= S_IDLE;
                    cnt      <= 4'd0;
                    lat_sel  <= 4'd0;
                    lat_idx  <= '0;
                    lat_data <= 32'd0;
                end else begin
                    state <= state_next;
                    case (state)
                        S_IDLE: begin
                            if (en) begin
                                lat_sel  <= write_sel;
                                lat_idx  <= idx;
                                lat_data <= data_in;
                                cnt      <= 4'(WAIT_CYCLES - 1);
                            end
                        end
                        S_WAIT: begin
                            if (cnt != 4'd0) cnt <= cnt - 4'd1;
                        end
                        default: ;
                    endcase
                end
            end

            // stall is combinational on en in IDLE so the core freezes in the request cycle itself.
            always_comb begin
                state_next = state;
                stall      = 1'b0;
                do_access  = 1'b0;
                case (state)
                    S_IDLE: begin
                        stall = en;
                        if (en) state_next = S_WAIT;
                    end
                    S_WAIT: begin
                        stall = 1'b1;
                        if (cnt == 4'd0) begin
                            do_access  = 1'b1;
                            state_next = S_DONE;
                        end
                    end
                    S_DONE:  state_next = S_IDLE;
                    default: state_next = S_IDLE;
                endcase
            end

            assign acc_sel  = lat_sel;
            assign acc_idx  = lat_idx;
            assign acc_data = lat_data;
        end
    endgenerate

    // RAM contents survive reset; a reset edge only suppresses the commit.
    always_ff @(posedge clk) begin
        if (!rst && do_access && (acc_sel != 4'd0)) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_sel[i]) mem[acc_idx][8*i +: 8] <= acc_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= 32'd0;
        end else if (do_access && (acc_sel == 4'd0)) begin
            data_out <= mem[acc_idx];
        end
    end

`ifdef DATA_RAM_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count <= 32'd0;
            wr_count <= 32'd0;
        end else if (do_access) begin
            if (acc_sel == 4'd0) rd_count <= rd_count + 32'd1;
            else                 wr_count <= wr_count + 32'd1;
        end
    end
`endif

endmodule
